display_scan_ctrl: RTL

//   Time-multiplexes one shared BCD-to-7-segment decoder (4-bit in, active-low segments out)

---
 rtl/display_scan_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Scan controller that shares one BCD-to-7-segment decoder across N_DIGITS anodes.
// Each digit visit is an all-off blanking gap followed by a lit window, which avoids ghosting.
module display_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   digitos,
  input  logic                    carregar,
  input  logic                    supr_zeros,
  output logic [3:0]              bcd_out,
  output logic [N_DIGITS-1:0]     anodo,
  output logic                    quadro
);

  localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = $clog2(N_DIGITS);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    quadro_q, quadro_d;

  logic [3:0]              sel_nib;
  logic                    upper_zero;
  logic [3:0]              sel;
  logic [N_DIGITS-1:0]     onehot;

  // A digit counts as a leading zero when it and all higher digits are zero
  always_comb begin
    sel_nib    = shadow_q[4*idx_q +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(idx_q) && shadow_q[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    sel = (supr_zeros && idx_q != '0 && upper_zero) ? 4'hF : sel_nib;
  end

  assign onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bcd_d    = bcd_q;
    an_d     = an_q;
    quadro_d = 1'b0;
    shadow_d = carregar ? digitos : shadow_q;
    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == '0) begin
          bcd_d = sel;
          cnt_d = CW'(1);
        end else if (cnt_q == BLK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          an_d    = ~onehot;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d  = S_BLANK;
          cnt_d    = '0;
          an_d     = '1;
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          quadro_d = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      bcd_q    <= 4'hF;
      an_q     <= '1;
      quadro_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
      quadro_q <= quadro_d;
    end
  end

  assign bcd_out = bcd_q;
  assign anodo   = an_q;
  assign quadro  = quadro_q;

endmodule
